// File: rtl/nri_div_unit.sv
// nri_div_unit: iterative N-bit integer divider for RISC-V DIV/DIVU/REM/REMU.
//   The file also holds nri_div_row, the single-step non-restoring row that the
//   unit drives once per CALC cycle.
//   Optional feature macro: NRI_DIV_EARLY_OUT_EN. When defined, divide-by-zero
//   and signed-overflow operand pairs finish straight from accept.
// Ports (nri_div_unit):
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_valid / o_ready         request handshake (o_ready high only in IDLE)
//   i_op                      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_dividend, i_divisor     rs1, rs2
//   i_flush                   synchronous abort
//   o_valid / i_ready         result handshake
//   o_result                  quotient or remainder

// One non-restoring step: shift the next dividend bit into the partial
// remainder, then add or subtract the divisor depending on relative signs.
module nri_div_row #(
  parameter int unsigned N = 32
) (
  input  logic [N:0]   i_r,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_d,
  input  logic         i_signed,
  output logic [N:0]   o_r,
  output logic [N-1:0] o_q
);

  if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("nri_div_row: N must be a power of 2 and at least 4");
  end

  logic [N+1:0] d_ext_c;
  logic [N+1:0] shifted_c;
  logic [N+1:0] next_c;
  logic         same_sign_c;
  logic         q_bit_c;

  always_comb begin
    d_ext_c     = i_signed ? {{2{i_d[N-1]}}, i_d} : {2'b00, i_d};
    // 2r + next dividend bit needs one more bit than r itself.
    shifted_c   = {i_r, i_q[N-1]};
    same_sign_c = (i_r[N] == d_ext_c[N+1]);
    next_c      = same_sign_c ? (shifted_c - d_ext_c) : (shifted_c + d_ext_c);
    // Quotient bit is 1 when the new remainder keeps the divisor's sign.
    q_bit_c     = (next_c[N+1] == d_ext_c[N+1]);
    o_r         = next_c[N:0];
    o_q         = {i_q[N-2:0], q_bit_c};
  end

endmodule

module nri_div_unit #(
  parameter int unsigned N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result
);

  if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("nri_div_unit: N must be a power of 2 and at least 4");
  end

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_rem;
  logic          sign_q;
  logic          sign_r;
  logic          div_zero;
  logic          ovf;
  logic [N-1:0]  a_raw;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;

  logic          in_signed_c;
  logic          in_zero_c;
  logic          in_ovf_c;
  logic [N-1:0]  abs_a_c;
  logic [N-1:0]  abs_b_c;
  logic [N:0]    row_r_c;
  logic [N-1:0]  row_q_c;
  logic [N-1:0]  rem_mag_c;
  logic [N-1:0]  res_q_c;
  logic [N-1:0]  res_r_c;
  logic [N-1:0]  fix_result_c;

  // Special-case results: x/0 -> all ones, rem a; overflow -> a, rem 0.
  function automatic logic [N-1:0] special_result(input logic rem,
                                                  input logic zero,
                                                  input logic [N-1:0] a);
    if (zero) return rem ? a : '1;
    return rem ? '0 : a;
  endfunction

  // Operand decode and magnitude conversion at accept.
  always_comb begin
    in_signed_c = ~i_op[0];
    in_zero_c   = (i_divisor == '0);
    in_ovf_c    = in_signed_c && (i_dividend == {1'b1, {(N-1){1'b0}}}) &&
                  (i_divisor == '1);
    abs_a_c     = (in_signed_c && i_dividend[N-1]) ? -i_dividend : i_dividend;
    abs_b_c     = (in_signed_c && i_divisor[N-1])  ? -i_divisor  : i_divisor;
  end

  // The unit always divides magnitudes, so the row runs unsigned.
  nri_div_row #(.N(N)) u_row (
    .i_r      (r),
    .i_q      (q),
    .i_d      (d),
    .i_signed (1'b0),
    .o_r      (row_r_c),
    .o_q      (row_q_c)
  );

  // Remainder correction, sign fix-up and special-case override.
  always_comb begin
    // The true remainder lies in [0, d), so N-bit wraparound is exact.
    rem_mag_c = r[N] ? (r[N-1:0] + d) : r[N-1:0];
    res_q_c   = sign_q ? -q : q;
    res_r_c   = sign_r ? -rem_mag_c : rem_mag_c;
    if (div_zero || ovf) fix_result_c = special_result(is_rem, div_zero, a_raw);
    else                 fix_result_c = is_rem ? res_r_c : res_q_c;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
      cnt      <= '0;
      r        <= '0;
      q        <= '0;
      d        <= '0;
      is_rem   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      a_raw    <= '0;
    end else if (i_flush) begin
      state   <= S_IDLE;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            is_rem   <= i_op[1];
            sign_q   <= in_signed_c && (i_dividend[N-1] ^ i_divisor[N-1]);
            sign_r   <= in_signed_c && i_dividend[N-1];
            div_zero <= in_zero_c;
            ovf      <= in_ovf_c;
            a_raw    <= i_dividend;
            r        <= '0;
            q        <= abs_a_c;
            d        <= abs_b_c;
            cnt      <= CW'(N - 1);
            o_ready  <= 1'b0;
            state    <= S_CALC;
`ifdef NRI_DIV_EARLY_OUT_EN
            if (in_zero_c || in_ovf_c) begin
              o_result <= special_result(i_op[1], in_zero_c, i_dividend);
              state    <= S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          r   <= row_r_c;
          q   <= row_q_c;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          r        <= {1'b0, rem_mag_c};
          o_result <= fix_result_c;
          state    <= S_DONE;
        end
        S_DONE: begin
          // o_valid rises one cycle after entering DONE.
          if (!o_valid) begin
            o_valid <= 1'b1;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nri_div_unit.sv
// Directed bench for nri_div_unit (N=32).
module tb_nri_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  localparam int NORM_LAT = 34;
`ifdef NRI_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  nri_div_unit #(.N(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the result, optionally stall i_ready, then retire it.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int exp_lat, input int hold);
    int   lat;
    logic busy_bad;
    @(negedge clk);
    check({tag, " ready_before"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_op = op; i_dividend = a; i_divisor = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    busy_bad = 1'b0;
    while (o_valid !== 1'b1 && lat < 100) begin
      if (o_ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, o_result, exp);
    check({tag, " ready_busy"}, 32'(busy_bad | o_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold_valid"}, 32'(o_valid), 32'd1);
      check({tag, " hold_result"}, o_result, exp);
      check({tag, " hold_ready"}, 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check({tag, " ready_after"}, 32'(o_ready), 32'd1);
    check({tag, " valid_after"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic saw_valid;
    rst_n = 1'b0; i_valid = 1'b0; i_op = 2'b00; i_dividend = '0; i_divisor = '0;
    i_flush = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(o_ready), 32'd1);
    check("reset valid", 32'(o_valid), 32'd0);
    check("reset result", o_result, 32'd0);
    rst_n = 1'b1;

    do_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, NORM_LAT, 0);
    do_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, NORM_LAT, 0);
    do_op("div -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORM_LAT, 0);
    do_op("rem -7/2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORM_LAT, 0);
    do_op("div 7/-2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM_LAT, 0);
    do_op("rem 7/-2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, NORM_LAT, 0);
    do_op("div ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, 0);
    do_op("rem ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT, 0);
    do_op("divu 5/0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 0);
    do_op("rem 5/0",    OP_REM,  32'd5, 32'd0, 32'd5, SPEC_LAT, 0);
    do_op("div -7/0",   OP_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 0);
    do_op("rem -7/0",   OP_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPEC_LAT, 0);
    do_op("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORM_LAT, 0);
    do_op("divu 0x80000000 unsigned", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORM_LAT, 0);
    do_op("hold divu",  OP_DIVU, 32'd100, 32'd7, 32'd14, NORM_LAT, 10);
    do_op("remu 0x12345678/0x10000", OP_REMU, 32'h1234_5678, 32'h0001_0000, 32'h0000_5678, NORM_LAT, 0);

    // Flush during CALC cycle 5.
    @(negedge clk);
    i_valid = 1'b1; i_op = OP_DIVU; i_dividend = 32'd100; i_divisor = 32'd7;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush ready", 32'(o_ready), 32'd1);
    check("flush valid", 32'(o_valid), 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0) saw_valid = 1'b1;
    end
    check("flush no_valid", 32'(saw_valid), 32'd0);

    // A request alongside flush is not accepted.
    @(negedge clk);
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush+valid ready", 32'(o_ready), 32'd1);

    do_op("divu 1000/10", OP_DIVU, 32'd1000, 32'd10, 32'd100, NORM_LAT, 0);

    // Reset pulse mid-CALC.
    @(negedge clk);
    i_valid = 1'b1; i_op = OP_DIV; i_dividend = 32'd77; i_divisor = 32'd5;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset ready", 32'(o_ready), 32'd1);
    check("midreset valid", 32'(o_valid), 32'd0);
    check("midreset result", o_result, 32'd0);

    do_op("div -100/7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NORM_LAT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
